rca_seq_adder: RTL and testbench



---
 rtl/rca_seq_adder_pkg.sv | 19 +
 rtl/rca_nbit.sv | 22 ++
 rtl/rca_seq_adder.sv | 160 ++++++++++++++++
 tb/tb_rca_seq_adder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_seq_adder_pkg.sv
// Shared definitions for the chunk-serial ripple-carry adder: FSM encoding,
// chunk-count helper and the WIDTH/CHUNK legality check.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nchunk(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    function automatic bit width_legal(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/rca_nbit.sv
// Combinational N-bit ripple-carry adder; also exposes the carry into the MSB
// so the caller can derive signed overflow.
module rca_nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [N:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign sum   = full[N-1:0];
    assign cout  = full[N];
    // Sum bit = a ^ b ^ carry_in, so the MSB carry-in falls out of the sum bit.
    assign c_msb = a[N-1] ^ b[N-1] ^ sum[N-1];

endmodule

// File: rtl/rca_seq_adder.sv
// Chunk-serial ripple-carry adder/subtractor with valid/ready on both sides.
// Define RCA_SEQ_FLAGS_EN to build the ovf/zero flag logic; otherwise both read 0.
module rca_seq_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if (!width_legal(WIDTH, CHUNK)) begin : g_illegal_width
            $error("rca_seq_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;

    logic [CHUNK-1:0]   a_slice;
    logic [CHUNK-1:0]   b_slice;
    logic [CHUNK-1:0]   chunk_sum;
    logic               chunk_cout;

`ifdef RCA_SEQ_FLAGS_EN
    logic               chunk_cmsb;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
`else
    logic               chunk_cmsb_unused;
`endif

    assign a_slice = a_q[idx_q*CHUNK +: CHUNK];
    assign b_slice = b_q[idx_q*CHUNK +: CHUNK];

    rca_nbit #(.N(CHUNK)) u_chunk (
        .a     (a_slice),
        .b     (b_slice),
        .cin   (carry_q),
        .sum   (chunk_sum),
        .cout  (chunk_cout),
`ifdef RCA_SEQ_FLAGS_EN
        .c_msb (chunk_cmsb)
`else
        .c_msb (chunk_cmsb_unused)
`endif
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
`ifdef RCA_SEQ_FLAGS_EN
        ovf_d   = ovf_q;
        zero_d  = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1, so the external carry-in is dropped.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[idx_q*CHUNK +: CHUNK] = chunk_sum;
                carry_d = chunk_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = chunk_cout;
`ifdef RCA_SEQ_FLAGS_EN
                    ovf_d   = chunk_cmsb ^ chunk_cout;
                    zero_d  = (s_d == '0);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef RCA_SEQ_FLAGS_EN
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
`ifdef RCA_SEQ_FLAGS_EN
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = cout_q;
`ifdef RCA_SEQ_FLAGS_EN
    assign ovf       = ovf_q;
    assign zero      = zero_q;
`else
    assign ovf       = 1'b0;
    assign zero      = 1'b0;
`endif

endmodule

// File: tb/tb_rca_seq_adder.sv
// Self-checking bench: a 4-bit-chunk and a single-chunk adder share stimulus and
// are compared against an arithmetic model of add/subtract with carry and overflow.
module tb_rca_seq_adder;

    localparam bit FLAGS =
`ifdef RCA_SEQ_FLAGS_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_ready;

    logic        in_ready4, out_valid4, cout4, ovf4, zero4;
    logic [15:0] s4;
    logic        in_ready16, out_valid16, cout16, ovf16, zero16;
    logic [15:0] s16;

    int          vectors = 0;
    int          miscompares = 0;

    logic [15:0] exp_s;
    logic        exp_cout;
    logic        exp_ovf;
    logic        exp_zero;

    always #5 clk = ~clk;

    rca_seq_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid4), .out_ready(out_ready),
        .s(s4), .cout(cout4), .ovf(ovf4), .zero(zero4)
    );

    rca_seq_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid16), .out_ready(out_ready),
        .s(s16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    function automatic void compareValue(input string name, input logic [31:0] act,
                                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    // Reference: plain unsigned/signed integer arithmetic on the operands.
    function automatic void modelOp(input logic [15:0] ma, input logic [15:0] mb,
                                    input logic mcin, input logic msub);
        int sa;
        int sb;
        int r_s;
        int r_u;
        sa = $signed(ma);
        sb = $signed(mb);
        if (msub) begin
            exp_s    = ma - mb;
            exp_cout = (ma >= mb);
            r_s      = sa - sb;
        end else begin
            r_u      = int'(ma) + int'(mb) + int'(mcin);
            exp_s    = r_u[15:0];
            exp_cout = (r_u > 65535);
            r_s      = sa + sb + int'(mcin);
        end
        exp_ovf  = FLAGS & ((r_s > 32767) || (r_s < -32768));
        exp_zero = FLAGS & (exp_s == 16'h0000);
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (out_valid4 === 1'b1) begin
                compareValue("s4", s4, exp_s);
                compareValue("cout4", cout4, exp_cout);
                compareValue("ovf4", ovf4, exp_ovf);
                compareValue("zero4", zero4, exp_zero);
                compareValue("in_ready4_in_done", in_ready4, 1'b0);
            end
            if (out_valid16 === 1'b1) begin
                compareValue("s16", s16, exp_s);
                compareValue("cout16", cout16, exp_cout);
                compareValue("ovf16", ovf16, exp_ovf);
                compareValue("zero16", zero16, exp_zero);
                compareValue("in_ready16_in_done", in_ready16, 1'b0);
            end
        end
    end

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (!(in_ready4 === 1'b1 && in_ready16 === 1'b1) && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) compareValue("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input logic [15:0] ia, input logic [15:0] ib,
                                 input logic icin, input logic isub);
        int lat4;
        int lat16;
        waitIdle();
        a = ia;
        b = ib;
        cin = icin;
        sub = isub;
        modelOp(ia, ib, icin, isub);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
        lat4 = 0;
        lat16 = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (out_valid4 === 1'b1 && lat4 == 0) lat4 = cyc;
            if (out_valid16 === 1'b1 && lat16 == 0) lat16 = cyc;
            if (lat4 != 0 && lat16 != 0) break;
        end
        compareValue("latency4", lat4, 4);
        compareValue("latency16", lat16, 1);
    endtask

    task automatic consumeResult(input int hold);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        compareValue("out_valid4_after_consume", out_valid4, 1'b0);
        compareValue("out_valid16_after_consume", out_valid16, 1'b0);
        compareValue("in_ready4_after_consume", in_ready4, 1'b1);
        compareValue("s4_held_after_consume", s4, exp_s);
        compareValue("s16_held_after_consume", s16, exp_s);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] rs, input logic rcout,
                               input logic rovf, input logic rzero);
        compareValue({name, "_s4"}, s4, rs);
        compareValue({name, "_cout4"}, cout4, rcout);
        compareValue({name, "_ovf4"}, ovf4, FLAGS & rovf);
        compareValue({name, "_zero4"}, zero4, FLAGS & rzero);
        compareValue({name, "_s16"}, s16, rs);
        compareValue({name, "_cout16"}, cout16, rcout);
        compareValue({name, "_ovf16"}, ovf16, FLAGS & rovf);
        compareValue({name, "_zero16"}, zero16, FLAGS & rzero);
        consumeResult(0);
    endtask

    initial begin
        logic [15:0] held_s;
        logic [15:0] picks [4];
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compareValue("reset_out_valid4", out_valid4, 1'b0);
        compareValue("reset_s4", s4, 16'h0000);
        compareValue("reset_cout4", cout4, 1'b0);
        compareValue("reset_ovf4", ovf4, 1'b0);
        compareValue("reset_zero4", zero4, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        compareValue("reset_in_ready4", in_ready4, 1'b1);
        compareValue("reset_in_ready16", in_ready16, 1'b1);

        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
        checkOutput("add_nocarry", 16'h5555, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        checkOutput("carry_ripple", 16'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
        checkOutput("sub_borrow", 16'hFFFE, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        checkOutput("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);
        applyStimulus(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        checkOutput("alt_cin", 16'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'h0010, 16'h0003, 1'b1, 1'b1);
        checkOutput("sub_ignores_cin", 16'h000D, 1'b1, 1'b0, 1'b0);

        // Backpressure on 0x8000-0x0001 while a competing request is offered.
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
        held_s = s4;
        in_valid = 1'b1;
        a = 16'h0101;
        b = 16'h0202;
        repeat (5) begin
            @(posedge clk);
            #1;
            compareValue("bp_in_ready4", in_ready4, 1'b0);
            compareValue("bp_out_valid4", out_valid4, 1'b1);
            compareValue("bp_s4_stable", s4, held_s);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        compareValue("bp_consumed_out_valid4", out_valid4, 1'b0);
        compareValue("bp_in_ready4_next", in_ready4, 1'b1);
        @(posedge clk);
        #1;
        compareValue("bp_no_accept_on_handshake", in_ready4, 1'b1);
        compareValue("bp_sub_ovf_s4", s4, 16'h7FFF);
        compareValue("bp_sub_ovf_cout4", cout4, 1'b1);
        compareValue("bp_sub_ovf_ovf4", ovf4, FLAGS);

        // Reset two cycles after accept aborts the operation.
        waitIdle();
        a = 16'h4444;
        b = 16'h1111;
        cin = 1'b0;
        sub = 1'b0;
        modelOp(a, b, cin, sub);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        compareValue("rst_mid_out_valid4", out_valid4, 1'b0);
        compareValue("rst_mid_s4", s4, 16'h0000);
        compareValue("rst_mid_in_ready4", in_ready4, 1'b1);
        compareValue("rst_mid_out_valid16", out_valid16, 1'b0);
        compareValue("rst_mid_s16", s16, 16'h0000);
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
        checkOutput("after_reset", 16'h0002, 1'b0, 1'b0, 1'b0);

        picks[0] = 16'h0000;
        picks[1] = 16'hFFFF;
        picks[2] = 16'h8000;
        picks[3] = 16'h7FFF;
        for (int n = 0; n < 150; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 3)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 3)] : 16'($urandom);
            applyStimulus(ra, rb, 1'($urandom), 1'($urandom));
            consumeResult($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
